// File: rtl/demosaic_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : demosaic_mem_arb
// Purpose  : Write-buffer plus memory-slot arbiter between the demosaic R/G/B
//            result writes and a host read port sharing one set of
//            single-port result SRAMs. Flags frame completion once the last
//            demosaic write has been committed to memory.
// Revision : 1.0 - initial release
// ============================================================================
module demosaic_mem_arb #(
  parameter int AW       = 14,
  parameter int DW       = 8,
  parameter int DEPTH    = 4,
  parameter int HI_WM    = 3,
  parameter int MAX_WAIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dm_wr_i,
  input  logic [AW-1:0]   dm_addr_i,
  input  logic [DW-1:0]   dm_wdata_r_i,
  input  logic [DW-1:0]   dm_wdata_g_i,
  input  logic [DW-1:0]   dm_wdata_b_i,
  input  logic            dm_done_i,
  input  logic            hr_req_i,
  input  logic [AW-1:0]   hr_addr_i,
  output logic            hr_gnt_o,
  output logic            hr_rvalid_o,
  output logic [3*DW-1:0] hr_rdata_o,
  output logic            mem_wr_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_r_o,
  output logic [DW-1:0]   mem_wdata_g_o,
  output logic [DW-1:0]   mem_wdata_b_o,
  input  logic [DW-1:0]   mem_rdata_r_i,
  input  logic [DW-1:0]   mem_rdata_g_i,
  input  logic [DW-1:0]   mem_rdata_b_i,
  output logic            ovf_o,
  output logic            frame_done_o
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_WT_W  = $clog2(MAX_WAIT + 1);
  localparam int c_ENT_W = AW + 3 * DW;

  localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_HI_WM    = c_CNT_W'(HI_WM);
  localparam logic [c_WT_W-1:0]  c_MAX_WAIT = c_WT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // FIFO entry layout: {addr, r, g, b}
  logic [c_ENT_W-1:0] fifo_q [DEPTH];
  logic [c_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [c_WT_W-1:0]  wait_q, wait_d;
  logic               ovf_q;
  state_e             state_q;

  logic               mem_wr_q;
  logic [AW-1:0]      mem_addr_q;
  logic [DW-1:0]      mem_wdata_r_q, mem_wdata_g_q, mem_wdata_b_q;

  // Read return pipeline: address on the bus, then SRAM data valid.
  logic               rd_p1_q, rd_p2_q;
  logic               hr_rvalid_q;
  logic [3*DW-1:0]    hr_rdata_q;

  logic [c_ENT_W-1:0] w_head;
  logic               w_full, w_force_host, w_force_wr, w_host_win;
  logic               w_pop, w_accept, w_push, w_drop, w_flush_end;

  // Slot arbitration and FIFO/wait-counter next state from registered state.
  always_comb begin
    w_head       = fifo_q[rd_ptr_q];
    w_full       = (cnt_q == c_DEPTH);
    w_force_host = hr_req_i && (wait_q == c_MAX_WAIT);
    w_force_wr   = (cnt_q >= c_HI_WM);
    // Grant is held low while reset is asserted so every output reads 0.
    w_host_win   = !reset && (w_force_host || (hr_req_i && !w_force_wr));
    w_pop        = !w_host_win && (cnt_q != '0);
    w_accept     = dm_wr_i && (state_q != S_DONE);
    w_push       = w_accept && (!w_full || w_pop);
    w_drop       = w_accept && w_full && !w_pop;
    // Nothing queued, nothing issued this cycle and nothing arriving: any
    // write still on the bus is committed at this edge.
    w_flush_end  = (state_q == S_FLUSH) && (cnt_q == '0) && !w_pop && !w_push;

    cnt_d = cnt_q;
    if (w_push && !w_pop) begin
      cnt_d = cnt_q + c_CNT_W'(1);
    end else if (!w_push && w_pop) begin
      cnt_d = cnt_q - c_CNT_W'(1);
    end

    wait_d = '0;
    if (hr_req_i && !w_host_win) begin
      wait_d = (wait_q == c_MAX_WAIT) ? wait_q : wait_q + c_WT_W'(1);
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_q[wr_ptr_q] <= {dm_addr_i, dm_wdata_r_i, dm_wdata_g_i, dm_wdata_b_i};
    end
  end

  // FIFO pointers, occupancy, host wait counter and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
      cnt_q  <= cnt_d;
      wait_q <= wait_d;
      if (w_drop) ovf_q <= 1'b1;
    end
  end

  // SRAM port: write slot drives the FIFO head, read slot the host address,
  // idle slot holds the previous address and data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_r_q <= '0;
      mem_wdata_g_q <= '0;
      mem_wdata_b_q <= '0;
    end else begin
      mem_wr_q <= w_pop;
      if (w_pop) begin
        mem_addr_q    <= w_head[c_ENT_W-1 -: AW];
        mem_wdata_r_q <= w_head[3*DW-1 -: DW];
        mem_wdata_g_q <= w_head[2*DW-1 -: DW];
        mem_wdata_b_q <= w_head[DW-1:0];
      end else if (w_host_win) begin
        mem_addr_q <= hr_addr_i;
      end
    end
  end

  // Host read return: capture SRAM data two cycles after the grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_p1_q     <= 1'b0;
      rd_p2_q     <= 1'b0;
      hr_rvalid_q <= 1'b0;
      hr_rdata_q  <= '0;
    end else begin
      rd_p1_q     <= w_host_win;
      rd_p2_q     <= rd_p1_q;
      hr_rvalid_q <= rd_p2_q;
      if (rd_p2_q) begin
        hr_rdata_q <= {mem_rdata_r_i, mem_rdata_g_i, mem_rdata_b_i};
      end
    end
  end

  // Frame FSM: RUN until the last pixel, FLUSH until memory is up to date.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
    end else begin
      case (state_q)
        S_RUN:   if (dm_done_i) state_q <= S_FLUSH;
        S_FLUSH: if (w_flush_end) state_q <= S_DONE;
        S_DONE:  state_q <= S_DONE;
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign hr_gnt_o      = w_host_win;
  assign hr_rvalid_o   = hr_rvalid_q;
  assign hr_rdata_o    = hr_rdata_q;
  assign mem_wr_o      = mem_wr_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_r_o = mem_wdata_r_q;
  assign mem_wdata_g_o = mem_wdata_g_q;
  assign mem_wdata_b_o = mem_wdata_b_q;
  assign ovf_o         = ovf_q;
  assign frame_done_o  = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_demosaic_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_demosaic_mem_arb
// Purpose  : Directed bench for demosaic_mem_arb: vector table for write and
//            read paths, hand sequences for watermark, overflow, frame end
//            and reset during flush.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demosaic_mem_arb;

  localparam logic [23:0] D82 = 24'h0A141E;
  localparam logic [23:0] R5  = 24'h112233;
  localparam logic [13:0] A82 = 14'h0082;
  localparam logic [13:0] A5  = 14'h0005;

  logic        clk;
  logic        reset;
  logic        dm_wr, dm_done, hr_req;
  logic [13:0] dm_addr, hr_addr;
  logic [7:0]  dm_r, dm_g, dm_b;
  logic        hr_gnt, hr_rvalid, mem_wr, ovf, frame_done;
  logic [23:0] hr_rdata;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata_r, mem_wdata_g, mem_wdata_b;
  logic [7:0]  mem_rdata_r, mem_rdata_g, mem_rdata_b;

  // Second instance for the overflow case (DEPTH=4, HI_WM=4, MAX_WAIT=1)
  logic        dm_wr2, hr_req2;
  logic [13:0] dm_addr2, hr_addr2;
  logic [7:0]  dm_d2, mem_rd2;
  logic        hr_gnt2, hr_rvalid2, mem_wr2, ovf2, frame_done2;
  logic [23:0] hr_rdata2;
  logic [13:0] mem_addr2;
  logic [7:0]  mem_wr2_r, mem_wr2_g, mem_wr2_b;

  int checks   = 0;
  int failures = 0;

  logic [23:0] sram [16384];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  demosaic_mem_arb dut (
    .clk(clk), .reset(reset),
    .dm_wr_i(dm_wr), .dm_addr_i(dm_addr),
    .dm_wdata_r_i(dm_r), .dm_wdata_g_i(dm_g), .dm_wdata_b_i(dm_b),
    .dm_done_i(dm_done), .hr_req_i(hr_req), .hr_addr_i(hr_addr),
    .hr_gnt_o(hr_gnt), .hr_rvalid_o(hr_rvalid), .hr_rdata_o(hr_rdata),
    .mem_wr_o(mem_wr), .mem_addr_o(mem_addr),
    .mem_wdata_r_o(mem_wdata_r), .mem_wdata_g_o(mem_wdata_g), .mem_wdata_b_o(mem_wdata_b),
    .mem_rdata_r_i(mem_rdata_r), .mem_rdata_g_i(mem_rdata_g), .mem_rdata_b_i(mem_rdata_b),
    .ovf_o(ovf), .frame_done_o(frame_done)
  );

  demosaic_mem_arb #(.DEPTH(4), .HI_WM(4), .MAX_WAIT(1)) dut2 (
    .clk(clk), .reset(reset),
    .dm_wr_i(dm_wr2), .dm_addr_i(dm_addr2),
    .dm_wdata_r_i(dm_d2), .dm_wdata_g_i(dm_d2), .dm_wdata_b_i(dm_d2),
    .dm_done_i(1'b0), .hr_req_i(hr_req2), .hr_addr_i(hr_addr2),
    .hr_gnt_o(hr_gnt2), .hr_rvalid_o(hr_rvalid2), .hr_rdata_o(hr_rdata2),
    .mem_wr_o(mem_wr2), .mem_addr_o(mem_addr2),
    .mem_wdata_r_o(mem_wr2_r), .mem_wdata_g_o(mem_wr2_g), .mem_wdata_b_o(mem_wr2_b),
    .mem_rdata_r_i(mem_rd2), .mem_rdata_g_i(mem_rd2), .mem_rdata_b_i(mem_rd2),
    .ovf_o(ovf2), .frame_done_o(frame_done2)
  );

  // Single-port SRAM model: write on mem_wr, registered read one cycle later.
  always @(posedge clk) begin
    if (mem_wr) sram[mem_addr] <= {mem_wdata_r, mem_wdata_g, mem_wdata_b};
    {mem_rdata_r, mem_rdata_g, mem_rdata_b} <= sram[mem_addr];
  end

  typedef struct {
    logic        dm_wr;
    logic [13:0] dm_addr;
    logic [23:0] dm_data;
    logic        hr_req;
    logic [13:0] hr_addr;
    logic        gnt;
    logic        mwr;
    logic [13:0] maddr;
    logic [23:0] mwdata;
    logic        rv;
    logic [23:0] rdata;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic w, input logic [13:0] a, input logic [23:0] d,
                              input logic rq, input logic [13:0] ha, input logic g,
                              input logic mw, input logic [13:0] ma, input logic [23:0] md,
                              input logic rv, input logic [23:0] rd);
    vec_t v;
    v.dm_wr = w;  v.dm_addr = a;  v.dm_data = d;  v.hr_req = rq; v.hr_addr = ha;
    v.gnt = g;    v.mwr = mw;     v.maddr = ma;   v.mwdata = md; v.rv = rv; v.rdata = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    dm_wr = 1'b0; dm_done = 1'b0; hr_req = 1'b0;
    dm_addr = '0; hr_addr = '0; dm_r = '0; dm_g = '0; dm_b = '0;
    dm_wr2 = 1'b0; hr_req2 = 1'b0; dm_addr2 = '0; hr_addr2 = '0; dm_d2 = '0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) sram[i] = 24'h0;
    sram[5] = R5;
    mem_rd2 = 8'h00;
    reset = 1'b0;
    idle_inputs();

    // ---------------- reset values ----------------
    #2 reset = 1'b1;
    @(negedge clk);
    chk("reset mem_wr", 32'(mem_wr), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_wdata", 32'({mem_wdata_r, mem_wdata_g, mem_wdata_b}), 32'd0);
    chk("reset hr_gnt", 32'(hr_gnt), 32'd0);
    chk("reset hr_rvalid", 32'(hr_rvalid), 32'd0);
    chk("reset hr_rdata", 32'(hr_rdata), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    chk("reset frame_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // ---------------- table: single write, reads, back-to-back reads ----------------
    vecs[0]  = mk(1'b1, A82, D82, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 24'h0, 1'b0, 24'h0);
    vecs[1]  = mk(1'b0, 14'h0, 24'h0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 24'h0, 1'b0, 24'h0);
    vecs[2]  = mk(1'b0, 14'h0, 24'h0, 1'b0, 14'h0, 1'b0, 1'b1, A82, D82, 1'b0, 24'h0);
    vecs[3]  = mk(1'b0, 14'h0, 24'h0, 1'b1, A5,    1'b1, 1'b0, A82, D82, 1'b0, 24'h0);
    vecs[4]  = mk(1'b0, 14'h0, 24'h0, 1'b0, 14'h0, 1'b0, 1'b0, A5,  D82, 1'b0, 24'h0);
    vecs[5]  = mk(1'b0, 14'h0, 24'h0, 1'b0, 14'h0, 1'b0, 1'b0, A5,  D82, 1'b0, 24'h0);
    vecs[6]  = mk(1'b0, 14'h0, 24'h0, 1'b0, 14'h0, 1'b0, 1'b0, A5,  D82, 1'b1, R5);
    vecs[7]  = mk(1'b0, 14'h0, 24'h0, 1'b0, 14'h0, 1'b0, 1'b0, A5,  D82, 1'b0, R5);
    vecs[8]  = mk(1'b0, 14'h0, 24'h0, 1'b1, A82,   1'b1, 1'b0, A5,  D82, 1'b0, R5);
    vecs[9]  = mk(1'b0, 14'h0, 24'h0, 1'b0, 14'h0, 1'b0, 1'b0, A82, D82, 1'b0, R5);
    vecs[10] = mk(1'b0, 14'h0, 24'h0, 1'b0, 14'h0, 1'b0, 1'b0, A82, D82, 1'b0, R5);
    vecs[11] = mk(1'b0, 14'h0, 24'h0, 1'b0, 14'h0, 1'b0, 1'b0, A82, D82, 1'b1, D82);
    vecs[12] = mk(1'b0, 14'h0, 24'h0, 1'b1, A5,    1'b1, 1'b0, A82, D82, 1'b0, D82);
    vecs[13] = mk(1'b0, 14'h0, 24'h0, 1'b1, A82,   1'b1, 1'b0, A5,  D82, 1'b0, D82);
    vecs[14] = mk(1'b0, 14'h0, 24'h0, 1'b0, 14'h0, 1'b0, 1'b0, A82, D82, 1'b0, D82);
    vecs[15] = mk(1'b0, 14'h0, 24'h0, 1'b0, 14'h0, 1'b0, 1'b0, A82, D82, 1'b1, R5);
    vecs[16] = mk(1'b0, 14'h0, 24'h0, 1'b0, 14'h0, 1'b0, 1'b0, A82, D82, 1'b1, D82);
    vecs[17] = mk(1'b0, 14'h0, 24'h0, 1'b0, 14'h0, 1'b0, 1'b0, A82, D82, 1'b0, D82);

    for (int i = 0; i < 18; i++) begin
      dm_wr   = vecs[i].dm_wr;
      dm_addr = vecs[i].dm_addr;
      {dm_r, dm_g, dm_b} = vecs[i].dm_data;
      hr_req  = vecs[i].hr_req;
      hr_addr = vecs[i].hr_addr;
      @(negedge clk);
      chk($sformatf("vec%0d hr_gnt", i), 32'(hr_gnt), 32'(vecs[i].gnt));
      chk($sformatf("vec%0d mem_wr", i), 32'(mem_wr), 32'(vecs[i].mwr));
      chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
      chk($sformatf("vec%0d mem_wdata", i), 32'({mem_wdata_r, mem_wdata_g, mem_wdata_b}),
          32'(vecs[i].mwdata));
      chk($sformatf("vec%0d hr_rvalid", i), 32'(hr_rvalid), 32'(vecs[i].rv));
      chk($sformatf("vec%0d hr_rdata", i), 32'(hr_rdata), 32'(vecs[i].rdata));
      next_cycle();
    end
    idle_inputs();

    // ---------------- watermark and starvation bound ----------------
    do_reset();
    for (int k = 0; k < 20; k++) begin
      logic exp_g, exp_w;
      logic [13:0] exp_a;
      hr_req = 1'b1; hr_addr = 14'h0010;
      dm_wr = 1'b1; dm_addr = 14'(k);
      dm_r = 8'(k); dm_g = 8'(k + 1); dm_b = 8'(k + 2);
      exp_g = (k <= 2) || (k == 11);
      exp_w = (k >= 4 && k <= 11) || (k >= 13);
      exp_a = (k <= 11) ? 14'(k - 4) : 14'(k - 5);
      @(negedge clk);
      chk($sformatf("wm%0d hr_gnt", k), 32'(hr_gnt), 32'(exp_g));
      chk($sformatf("wm%0d mem_wr", k), 32'(mem_wr), 32'(exp_w));
      if (exp_w) begin
        chk($sformatf("wm%0d mem_addr", k), 32'(mem_addr), 32'(exp_a));
        chk($sformatf("wm%0d mem_wdata_r", k), 32'(mem_wdata_r), 32'(exp_a[7:0]));
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    chk("wm ovf", 32'(ovf), 32'd0);
    next_cycle();

    // ---------------- overflow on the force-host cycle ----------------
    do_reset();
    for (int k = 0; k < 8; k++) begin
      logic exp_g, exp_o;
      hr_req2 = 1'b1; hr_addr2 = 14'h0003;
      dm_wr2 = 1'b1; dm_addr2 = 14'(k); dm_d2 = 8'(k);
      exp_g = (k <= 3) || (k == 5) || (k == 7);
      exp_o = (k >= 6);
      @(negedge clk);
      chk($sformatf("ovf%0d hr_gnt", k), 32'(hr_gnt2), 32'(exp_g));
      chk($sformatf("ovf%0d ovf", k), 32'(ovf2), 32'(exp_o));
      next_cycle();
    end
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ovf sticky%0d", k), 32'(ovf2), 32'd1);
      next_cycle();
    end
    do_reset();
    @(negedge clk);
    chk("ovf cleared by reset", 32'(ovf2), 32'd0);
    next_cycle();

    // ---------------- frame end ----------------
    do_reset();
    hr_req = 1'b1; hr_addr = 14'h0007;
    dm_wr = 1'b1; dm_addr = 14'd100; {dm_r, dm_g, dm_b} = 24'h010203;
    next_cycle();
    dm_addr = 14'd101; {dm_r, dm_g, dm_b} = 24'h040506;
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      hr_req = 1'b0;
      dm_wr = (k == 0); dm_done = (k == 0);
      dm_addr = 14'd16253; {dm_r, dm_g, dm_b} = 24'hAABBCC;
      @(negedge clk);
      chk($sformatf("fe%0d mem_wr", k), 32'(mem_wr), 32'((k >= 1) && (k <= 3)));
      chk($sformatf("fe%0d frame_done", k), 32'(frame_done), 32'(k >= 4));
      if (k == 1) chk("fe mem_addr 1", 32'(mem_addr), 32'd100);
      if (k == 2) chk("fe mem_addr 2", 32'(mem_addr), 32'd101);
      if (k == 3) chk("fe mem_addr 3", 32'(mem_addr), 32'd16253);
      next_cycle();
    end
    for (int k = 0; k < 6; k++) begin
      dm_wr = 1'b1; dm_addr = 14'(200 + k);
      @(negedge clk);
      chk($sformatf("done%0d mem_wr", k), 32'(mem_wr), 32'd0);
      chk($sformatf("done%0d ovf", k), 32'(ovf), 32'd0);
      chk($sformatf("done%0d frame_done", k), 32'(frame_done), 32'd1);
      next_cycle();
    end
    dm_wr = 1'b0;
    hr_req = 1'b1; hr_addr = 14'd16253;
    @(negedge clk);
    chk("done read hr_gnt", 32'(hr_gnt), 32'd1);
    next_cycle();
    hr_req = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("done read hr_rvalid", 32'(hr_rvalid), 32'd1);
    chk("done read hr_rdata", 32'(hr_rdata), 32'hAABBCC);
    next_cycle();

    // ---------------- reset mid-flush with a read in flight ----------------
    do_reset();
    hr_req = 1'b1; hr_addr = A5;
    dm_wr = 1'b1; dm_addr = 14'd300; {dm_r, dm_g, dm_b} = 24'h0F0F0F;
    next_cycle();
    dm_addr = 14'd301; dm_done = 1'b1;
    next_cycle();
    dm_wr = 1'b0; dm_done = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid reset mem_wr", 32'(mem_wr), 32'd0);
    chk("mid reset mem_addr", 32'(mem_addr), 32'd0);
    chk("mid reset mem_wdata", 32'({mem_wdata_r, mem_wdata_g, mem_wdata_b}), 32'd0);
    chk("mid reset hr_gnt", 32'(hr_gnt), 32'd0);
    chk("mid reset hr_rvalid", 32'(hr_rvalid), 32'd0);
    chk("mid reset hr_rdata", 32'(hr_rdata), 32'd0);
    chk("mid reset ovf", 32'(ovf), 32'd0);
    chk("mid reset frame_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("post%0d hr_rvalid", k), 32'(hr_rvalid), 32'd0);
      chk($sformatf("post%0d mem_wr", k), 32'(mem_wr), 32'd0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
